// File: rtl/booth_algorithm_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/sub plus arithmetic right shift per cycle,
// producing the full 2N-bit signed product N cycles after an accepted start.
module booth_algorithm_multiplier #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   X,
    input  logic [N-1:0]   Y,
    output logic [2*N-1:0] Product,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [N:0]     r_m;
    logic [N:0]     r_a;
    logic [N-1:0]   r_q;
    logic           r_q_1;
    logic [CW-1:0]  r_count;
    logic [2*N-1:0] r_product;
    logic           r_busy;
    logic           r_done;

    logic [N:0]     w_a_sum;
    logic [N:0]     w_a_shift;
    logic [N-1:0]   w_q_shift;
    logic           w_last;

    assign w_last = (r_count == CW'(1));

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next_state = S_RUN;
            S_RUN:   if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Booth recoding of {Q[0],Q_1}; M is one bit wider than the operands so A cannot overflow.
    always_comb begin
        w_a_sum = r_a;
        unique case ({r_q[0], r_q_1})
            2'b01:   w_a_sum = r_a + r_m;
            2'b10:   w_a_sum = r_a - r_m;
            default: w_a_sum = r_a;
        endcase
    end

    assign w_a_shift = {w_a_sum[N], w_a_sum[N:1]};
    assign w_q_shift = {w_a_sum[0], r_q[N-1:1]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m       <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_q_1     <= 1'b0;
            r_count   <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m     <= {X[N-1], X};
                        r_a     <= '0;
                        r_q     <= Y;
                        r_q_1   <= 1'b0;
                        r_count <= CW'(N);
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_a     <= w_a_shift;
                    r_q     <= w_q_shift;
                    r_q_1   <= r_q[0];
                    r_count <= r_count - 1'b1;
                    if (w_last) begin
                        r_product <= {w_a_shift[N-1:0], w_q_shift};
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign Product = r_product;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_booth_algorithm_multiplier.sv
// Scoreboard bench: stimulus pushes X*Y (plain signed arithmetic) and the expected done cycle;
// a monitor pops and compares on every done pulse and watches Product stability while busy.
module tb_booth_algorithm_multiplier;

    localparam int N = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   X;
    logic [N-1:0]   Y;
    logic [2*N-1:0] Product;
    logic           busy;
    logic           done;

    booth_algorithm_multiplier #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .X       (X),
        .Y       (Y),
        .Product (Product),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cycle_cnt = 0;

    logic [2*N-1:0] exp_q[$];
    int             due_q[$];
    logic [2*N-1:0] last_prod = '0;
    logic           prev_done = 1'b0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*N-1:0] ref_mul(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
        logic signed [2*N-1:0] ea;
        logic signed [2*N-1:0] eb;
        ea = a;
        eb = b;
        return ea * eb;
    endfunction

    // Monitor: decoupled from stimulus, compares whenever the DUT presents a result.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                check("busy_low_on_done", busy, 0);
                check("done_one_cycle", prev_done, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    last_prod = exp_q.pop_front();
                    check("product", Product, last_prod);
                    check("latency", cycle_cnt, due_q.pop_front());
                end
            end else if (busy) begin
                check("product_hold", Product, last_prod);
            end
        end
        prev_done = done;
    end

    task automatic wait_idle();
        int t = 0;
        while ((busy || done) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", busy || done, 0);
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
        wait_idle();
        X     = a;
        Y     = b;
        start = 1'b1;
        exp_q.push_back(ref_mul(a, b));
        due_q.push_back(cycle_cnt + 1 + N);
        @(negedge clk);
        start = 1'b0;
        X     = $urandom;
        Y     = $urandom;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", done, 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        X     = '0;
        Y     = '0;
        repeat (2) @(negedge clk);
        check("reset_product", Product, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'd211819911, 32'd12345);
        run_op(32'd32, 32'd23);
        run_op(-32'sd2111, -32'sd552233);
        run_op(32'd502, -32'sd4);
        run_op(-32'sd2111, 32'd125);
        run_op(32'd1822436743, 32'd0);
        run_op(32'd0, 32'd0);
        run_op(32'd123456789, 32'd1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'h8000_0000, 32'h8000_0000);
        run_op(32'h7FFF_FFFF, 32'h8000_0000);
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);

        // start pulsed mid-run must not disturb the accepted operands
        run_op(32'd77777, -32'sd999);
        repeat (5) @(negedge clk);
        X     = 32'd5;
        Y     = 32'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // start during the done cycle must be ignored as well
        wait_done();
        X     = 32'd9;
        Y     = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", busy, 0);

        for (int i = 0; i < 20; i++) begin
            run_op($urandom, $urandom);
        end

        // asynchronous reset mid-run aborts the operation
        run_op(32'd4242, 32'd31337);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_product", Product, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        exp_q.delete();
        due_q.delete();
        last_prod = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (N + 4) @(negedge clk);
        check("no_done_after_abort", done, 0);

        run_op(-32'sd123, 32'd456);
        run_op($urandom, $urandom);

        begin
            int t = 0;
            while (exp_q.size() != 0 && t < 500) begin
                @(negedge clk);
                t++;
            end
        end
        check("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
